tile_draw_arbiter: RTL
======================

Name: tile_draw_arbiter

Overview:
- Owns the shared 8x8 tile-draw datapath: VGA tile loader, colour select and pixel counter.
- Serialises draw jobs from two requesters:
  - requester 0: sequence-playback controller (flash/restore of generated sequence).
  - requester 1: player-input feedback (flash of the tile the player pressed).
- Round-robin arbitration; one whole tile job per grant.
- Generates the load/write strobes and pixel index the datapath consumes, with a settle cycle and an inter-job gap, so colour and coordinates never change mid-tile.

Parameters:
PIXELS, 64, pixels written per tile job (8x8); counter terminal value is PIXELS-1
CW, 6, width of pixel_index; must satisfy 2^CW >= PIXELS
GAP, 2, idle cycles after each job before re-arbitration; legal range 1..15

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; one clock with reset=1 returns block to IDLE
req0  in  1  requester 0 job request, level, held until gnt0
tile0  in  2  requester 0 tile number (0..3)
flash0  in  1  requester 0 colour: 1=flash colour, 0=base colour
req1  in  1  requester 1 job request, level, held until gnt1
tile1  in  2  requester 1 tile number
flash1  in  1  requester 1 colour select
gnt0  out  1  one-cycle pulse: requester 0 job accepted
gnt1  out  1  one-cycle pulse: requester 1 job accepted
done0  out  1  one-cycle pulse: requester 0 job fully written
done1  out  1  one-cycle pulse: requester 1 job fully written
tile_num  out  2  latched tile number of current job to datapath
ld_tile  out  1  load base colour + tile origin (LOAD state, flash=0)
ld_flash  out  1  load flash colour + tile origin (LOAD state, flash=1)
writeEnable  out  1  pixel write strobe to VGA adapter
counterEnable  out  1  advance datapath pixel counter; identical to writeEnable
pixel_index  out  CW  current pixel 0..PIXELS-1 during DRAW, else 0
busy  out  1  1 in every state except IDLE

Behaviour:
- Reset (sync): state=IDLE, all outputs 0, tile_num=0, pixel_index=0, latched job cleared, last_winner=1 (so req0 wins first tie).
- Reset mid-job aborts the job: no done pulse, no further writes after the reset edge; requester must re-request.
- States:
  - IDLE -> LOAD: taken when req0|req1 sampled at the edge.
    - Winner: the only requester, or on a tie the one != last_winner.
    - On the same edge: latch winner's tile/flash, update last_winner.
    - gnt of winner is high for exactly the LOAD cycle.
  - LOAD (1 cycle): tile_num=latched tile; ld_flash=latched flash, ld_tile=~latched flash (mutually exclusive); no write.
  - SETTLE (1 cycle): datapath settle; all strobes 0; pixel_index=0.
  - DRAW (PIXELS cycles): writeEnable=counterEnable=1; pixel_index=0,1,...,PIXELS-1; exits after PIXELS-1.
  - GAP (GAP cycles): strobes 0; done of the job owner pulses in the first GAP cycle only; then IDLE.
- tile_num holds the latched value from LOAD until the next LOAD.
- Latency: req sampled at edge ending cycle T gives:
  - gnt/LOAD at T+1, SETTLE at T+2, DRAW at T+3..T+PIXELS+2.
  - done at T+PIXELS+3, IDLE at T+PIXELS+GAP+3.
- Defaults (PIXELS=64, GAP=2): IDLE at T+69; earliest next gnt at T+70.
- Requests are only sampled in IDLE.
  - req held during LOAD..GAP is ignored; a requester still asserting req after its done is served again (subject to round-robin).
  - req dropped before grant: never granted; no stale state.
- tile/flash inputs are don't-care except on the grant edge; changes during a job do not affect outputs.
- pixel_index wraps never: the counter stops at PIXELS-1 and returns to 0 in GAP.
- At most one gnt and one done per cycle; gnt0&gnt1 and done0&done1 are never both 1.

Test Plan:
- Single job: reset, req0=1 tile0=2 flash0=1 held until gnt0 -> gnt0 one cycle with ld_flash=1, ld_tile=0, tile_num=2; exactly 64 writeEnable cycles, pixel_index 0..63; done0 two cycles after gnt0+64 (T+67); busy low at T+69.
- Simultaneous first request: req0=req1=1 after reset -> requester 0 granted first; requester 1 granted at first IDLE after done0 (T+70); its tile1=3 flash1=0 gives ld_tile=1, tile_num=3.
- Round-robin fairness: both reqs held continuously for 4 jobs -> grant order 0,1,0,1; no gnt while busy=1.
- Input change mid-job: change tile0 from 1 to 0 during DRAW -> tile_num stays 1 and write count stays 64.
- Reset mid-DRAW: assert reset at pixel_index=30 -> next cycle writeEnable=0, busy=0, no done0; a new req0 afterwards completes a full 64-pixel job.
- Dropped request: req1 pulsed for 1 cycle while busy -> never granted, no done1.

Source files
------------

// File: rtl/tile_draw_arbiter_if.sv
// ---------------------------------------------------------------------------
// tile_draw_arbiter_if
// Bundles the two requester handshakes and the tile-draw datapath controls
// driven by tile_draw_arbiter.
//   requester side : req0/tile0/flash0, req1/tile1/flash1 (to arbiter)
//                    gnt0/done0, gnt1/done1 (from arbiter)
//   datapath side  : tile_num, ld_tile, ld_flash, writeEnable, counterEnable,
//                    pixel_index, busy (from arbiter)
// Modports: slave = arbiter, master = requesters + datapath consumer.
// ---------------------------------------------------------------------------
interface tile_draw_arbiter_if #(
   parameter int CW = 6
);
   logic          req0;
   logic [1:0]    tile0;
   logic          flash0;
   logic          req1;
   logic [1:0]    tile1;
   logic          flash1;
   logic          gnt0;
   logic          gnt1;
   logic          done0;
   logic          done1;
   logic [1:0]    tile_num;
   logic          ld_tile;
   logic          ld_flash;
   logic          writeEnable;
   logic          counterEnable;
   logic [CW-1:0] pixel_index;
   logic          busy;

   modport slave (
      input  req0, tile0, flash0, req1, tile1, flash1,
      output gnt0, gnt1, done0, done1, tile_num, ld_tile, ld_flash,
             writeEnable, counterEnable, pixel_index, busy
   );

   modport master (
      output req0, tile0, flash0, req1, tile1, flash1,
      input  gnt0, gnt1, done0, done1, tile_num, ld_tile, ld_flash,
             writeEnable, counterEnable, pixel_index, busy
   );
endinterface

// File: rtl/tile_draw_arbiter.sv
// ---------------------------------------------------------------------------
// tile_draw_arbiter
// Round-robin arbiter owning the shared 8x8 tile-draw datapath. Each grant
// runs one whole tile job: LOAD (colour/origin load), SETTLE, DRAW
// (PIXELS write strobes), then GAP idle cycles before re-arbitration.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous active-high reset, returns to IDLE and aborts a job
//   bus   : tile_draw_arbiter_if.slave, requester handshakes + datapath
//           strobes (see interface header)
// ---------------------------------------------------------------------------
module tile_draw_arbiter #(
   parameter int PIXELS = 64,
   parameter int CW     = 6,
   parameter int GAP    = 2
) (
   input logic               clock,
   input logic               reset,
   tile_draw_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_DRAW,
      S_GAP
   } state_t;

   localparam logic [CW-1:0] LAST_PIX = CW'(PIXELS - 1);
   localparam logic [CW-1:0] ONE_PIX  = CW'(1);
   localparam logic [3:0]    LAST_GAP = 4'(GAP - 1);
   localparam logic [3:0]    ONE_GAP  = 4'd1;

   state_t        state;
   state_t        next_state;
   logic [1:0]    job_tile;
   logic          job_flash;
   logic          job_owner;
   logic          last_winner;
   logic [CW-1:0] pix_cnt;
   logic [3:0]    gap_cnt;

   logic          any_req;
   logic          pick1;

   logic          gnt0_c;
   logic          gnt1_c;
   logic          done0_c;
   logic          done1_c;
   logic          ld_tile_c;
   logic          ld_flash_c;
   logic          write_c;
   logic [CW-1:0] pixel_c;

   // On a tie the requester that did not win last time is chosen.
   assign any_req = bus.req0 | bus.req1;
   assign pick1   = bus.req1 & (~bus.req0 | ~last_winner);

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Job latch and pixel/gap counters; the job is captured on the grant
   // edge so later input changes cannot disturb a tile mid-draw.
   always_ff @(posedge clock) begin
      if (reset) begin
         job_tile    <= 2'd0;
         job_flash   <= 1'b0;
         job_owner   <= 1'b0;
         last_winner <= 1'b1;
         pix_cnt     <= '0;
         gap_cnt     <= '0;
      end else begin
         if (state == S_IDLE && any_req) begin
            job_owner   <= pick1;
            last_winner <= pick1;
            job_tile    <= pick1 ? bus.tile1  : bus.tile0;
            job_flash   <= pick1 ? bus.flash1 : bus.flash0;
         end
         // Counter saturates at the last pixel and falls back to 0 in GAP.
         if (state == S_DRAW && pix_cnt != LAST_PIX) begin
            pix_cnt <= pix_cnt + ONE_PIX;
         end else begin
            pix_cnt <= '0;
         end
         if (state == S_GAP && gap_cnt != LAST_GAP) begin
            gap_cnt <= gap_cnt + ONE_GAP;
         end else begin
            gap_cnt <= '0;
         end
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (any_req) next_state = S_LOAD;
         S_LOAD:   next_state = S_SETTLE;
         S_SETTLE: next_state = S_DRAW;
         S_DRAW:   if (pix_cnt == LAST_PIX) next_state = S_GAP;
         S_GAP:    if (gap_cnt == LAST_GAP) next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Output decode; done fires only in the first GAP cycle.
   always_comb begin
      gnt0_c     = 1'b0;
      gnt1_c     = 1'b0;
      done0_c    = 1'b0;
      done1_c    = 1'b0;
      ld_tile_c  = 1'b0;
      ld_flash_c = 1'b0;
      write_c    = 1'b0;
      pixel_c    = '0;
      case (state)
         S_LOAD: begin
            gnt0_c     = ~job_owner;
            gnt1_c     = job_owner;
            ld_flash_c = job_flash;
            ld_tile_c  = ~job_flash;
         end
         S_DRAW: begin
            write_c = 1'b1;
            pixel_c = pix_cnt;
         end
         S_GAP: begin
            if (gap_cnt == 4'd0) begin
               done0_c = ~job_owner;
               done1_c = job_owner;
            end
         end
         default: begin
         end
      endcase
   end

   assign bus.gnt0          = gnt0_c;
   assign bus.gnt1          = gnt1_c;
   assign bus.done0         = done0_c;
   assign bus.done1         = done1_c;
   assign bus.tile_num      = job_tile;
   assign bus.ld_tile       = ld_tile_c;
   assign bus.ld_flash      = ld_flash_c;
   assign bus.writeEnable   = write_c;
   assign bus.counterEnable = write_c;
   assign bus.pixel_index   = pixel_c;
   assign bus.busy          = (state != S_IDLE);

endmodule
